// File: rtl/dma_dev_arbiter.sv
// dma_dev_arbiter: round-robin sharing of the DMA device port among N_DEV peripherals,
// with descriptor latching, granted-device routing and a stall watchdog.
module dma_dev_arbiter #(
    parameter int N_DEV    = 4,
    parameter int ADD_LEN  = 16,
    parameter int DATA_LEN = 16,
    parameter int WD_LEN   = 12,
    parameter int WD_LIMIT = 2048
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_DEV-1:0]          req_rqst,
    input  logic [N_DEV-1:0]          req_rd_wr,
    input  logic [N_DEV*ADD_LEN-1:0]  req_num_words,
    input  logic [N_DEV*(ADD_LEN+1)-1:0] req_start_addr,
    input  logic [N_DEV-1:0]          req_ack,
    input  logic [N_DEV*DATA_LEN-1:0] req_data_in,
    output logic [N_DEV-1:0]          grant,
    output logic [N_DEV-1:0]          req_dma_ack,
    output logic [DATA_LEN-1:0]       req_data_out,
    output logic [N_DEV-1:0]          req_end,
    output logic [N_DEV-1:0]          req_error,
    output logic [ADD_LEN-1:0]        dma_num_words,
    output logic [ADD_LEN:0]          dma_start_addr,
    output logic                      dma_rd_wr,
    output logic                      dma_rqst,
    output logic                      dma_dev_ack,
    output logic [DATA_LEN-1:0]       dma_dev_in,
    output logic                      dma_rst,
    input  logic                      dma_ack_in,
    input  logic [DATA_LEN-1:0]       dma_dev_out,
    input  logic                      dma_end_flag,
    input  logic                      dma_error_flag
);
    localparam int IW = $clog2(N_DEV);
    localparam logic [IW:0] ND = (IW+1)'(N_DEV);
    localparam logic [WD_LEN-1:0] WD_MAX = WD_LEN'(WD_LIMIT);
    localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, BUSY = 3'd2, DONE = 3'd3, ABORT = 3'd4;

    logic [2:0]          state;
    logic [IW-1:0]       rr_ptr, g, off, pick, nxt_ptr;
    logic [IW:0]         sum;
    logic [2*N_DEV-1:0]  dbl;
    logic [WD_LEN-1:0]   wd, wd_nxt;
    logic                err, ab, g_ack, wd_hit, granted;

    // Rotate requests so the search always starts at rr_ptr, then map the offset back.
    assign dbl = {req_rqst, req_rqst} >> rr_ptr;
    always_comb begin
        off = '0;
        for (int k = N_DEV-1; k >= 0; k--)
            if (dbl[k]) off = IW'(k);
    end
    assign sum     = {1'b0, rr_ptr} + {1'b0, off};
    assign pick    = (sum >= ND) ? IW'(sum - ND) : sum[IW-1:0];
    assign nxt_ptr = (g == IW'(N_DEV-1)) ? '0 : g + 1'b1;

    assign granted      = |grant;
    assign g_ack        = granted & req_ack[g];
    assign dma_dev_ack  = g_ack;
    assign dma_dev_in   = granted ? req_data_in[g*DATA_LEN +: DATA_LEN] : '0;
    assign req_dma_ack  = dma_ack_in ? grant : '0;
    assign req_data_out = dma_dev_out;
    assign dma_rqst     = (state == ISSUE);
    assign dma_rst      = (state == ABORT);
    assign req_end      = ((state == DONE) || (state == ABORT && ab)) ? grant : '0;
    assign req_error    = ((state == DONE && err) || (state == ABORT && ab)) ? grant : '0;

    assign wd_nxt = (dma_ack_in | g_ack) ? '0 : wd + 1'b1;
    assign wd_hit = (WD_LIMIT != 0) && (wd_nxt == WD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            g              <= '0;
            grant          <= '0;
            err            <= 1'b0;
            ab             <= 1'b0;
            wd             <= '0;
            dma_num_words  <= '0;
            dma_start_addr <= '0;
            dma_rd_wr      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_rqst) begin
                    g              <= pick;
                    grant          <= N_DEV'(1) << pick;
                    dma_num_words  <= req_num_words[pick*ADD_LEN +: ADD_LEN];
                    dma_start_addr <= req_start_addr[pick*(ADD_LEN+1) +: ADD_LEN+1];
                    dma_rd_wr      <= req_rd_wr[pick];
                    state          <= ISSUE;
                end
                ISSUE: begin
                    wd    <= '0;
                    ab    <= 1'b0;
                    state <= BUSY;
                end
                BUSY: begin
                    err   <= err | dma_error_flag;
                    wd    <= wd_nxt;
                    state <= dma_end_flag ? DONE : (wd_hit ? ABORT : BUSY);
                end
                DONE: begin
                    grant  <= '0;
                    err    <= 1'b0;
                    rr_ptr <= nxt_ptr;
                    state  <= IDLE;
                end
                ABORT: begin
                    ab <= ~ab;
                    if (ab) begin
                        grant  <= '0;
                        err    <= 1'b0;
                        rr_ptr <= nxt_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_dev_arbiter.sv
// tb_dma_dev_arbiter: randomized transfers checked against a transaction-level
// round-robin model, plus directed watchdog and async-reset scenarios.
module tb_dma_dev_arbiter;
    localparam int N = 4, AL = 16, DL = 16;

    logic clk = 1'b0, reset;
    logic [N-1:0] req_rqst, req_rd_wr, req_ack, grant, req_dma_ack, req_end, req_error;
    logic [N*AL-1:0] req_num_words;
    logic [N*(AL+1)-1:0] req_start_addr;
    logic [N*DL-1:0] req_data_in;
    logic [DL-1:0] req_data_out, dma_dev_in, dma_dev_out;
    logic [AL-1:0] dma_num_words;
    logic [AL:0] dma_start_addr;
    logic dma_rd_wr, dma_rqst, dma_dev_ack, dma_rst, dma_ack_in, dma_end_flag, dma_error_flag;

    always #5 clk = ~clk;

    dma_dev_arbiter #(.N_DEV(N), .ADD_LEN(AL), .DATA_LEN(DL), .WD_LEN(12), .WD_LIMIT(16)) dut (
        .clk(clk), .reset(reset), .req_rqst(req_rqst), .req_rd_wr(req_rd_wr),
        .req_num_words(req_num_words), .req_start_addr(req_start_addr), .req_ack(req_ack),
        .req_data_in(req_data_in), .grant(grant), .req_dma_ack(req_dma_ack),
        .req_data_out(req_data_out), .req_end(req_end), .req_error(req_error),
        .dma_num_words(dma_num_words), .dma_start_addr(dma_start_addr), .dma_rd_wr(dma_rd_wr),
        .dma_rqst(dma_rqst), .dma_dev_ack(dma_dev_ack), .dma_dev_in(dma_dev_in),
        .dma_rst(dma_rst), .dma_ack_in(dma_ack_in), .dma_dev_out(dma_dev_out),
        .dma_end_flag(dma_end_flag), .dma_error_flag(dma_error_flag)
    );

    int total = 0, bad = 0, ptr = 0;
    logic [AL-1:0] nw[N];
    logic [AL:0]   sa[N];
    logic          rw[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_desc();
        for (int i = 0; i < N; i++) begin
            req_num_words[i*AL +: AL]        = nw[i];
            req_start_addr[i*(AL+1) +: AL+1] = sa[i];
            req_rd_wr[i]                     = rw[i];
        end
    endtask

    task automatic rand_desc();
        for (int i = 0; i < N; i++) begin
            nw[i] = AL'($urandom);
            sa[i] = (AL+1)'($urandom);
            rw[i] = 1'($urandom);
        end
        drive_desc();
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (((m >> ((p + k) % N)) & N'(1)) != 0) return (p + k) % N;
        return -1;
    endfunction

    task automatic idle_check(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("idle_grant", grant, 0);
            check("idle_rqst", dma_rqst, 0);
        end
    endtask

    // Entry: DUT idle with a nonzero req_rqst driven; exit: #1 after the edge back into idle.
    task automatic run_xfer(input logic [N-1:0] nxt);
        int g, len;
        logic [N-1:0] oh;
        logic [AL-1:0] enw;
        logic [AL:0] esa;
        logic erw, err;
        g = rr_pick(req_rqst, ptr);
        oh = N'(1) << g;
        enw = nw[g]; esa = sa[g]; erw = rw[g]; err = 1'b0;
        @(posedge clk); #1;
        check("grant", grant, oh);
        check("rqst_pulse", dma_rqst, 1);
        check("num_words", dma_num_words, enw);
        check("start_addr", dma_start_addr, esa);
        check("rd_wr", dma_rd_wr, erw);
        @(negedge clk);
        req_rqst = N'($urandom);
        rand_desc();
        @(posedge clk); #1;
        check("rqst_low", dma_rqst, 0);
        check("grant_hold", grant, oh);
        check("addr_hold", dma_start_addr, esa);
        len = $urandom_range(1, 6);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            req_ack        = N'($urandom);
            dma_ack_in     = 1'($urandom);
            req_data_in    = (N*DL)'({$urandom, $urandom});
            dma_dev_out    = DL'($urandom);
            dma_error_flag = ($urandom_range(0, 3) == 0);
            err = err | dma_error_flag;
            #1;
            check("dev_ack", dma_dev_ack, (req_ack >> g) & N'(1));
            check("dev_in", dma_dev_in, req_data_in[g*DL +: DL]);
            check("dma_ack", req_dma_ack, dma_ack_in ? oh : N'(0));
            check("data_out", req_data_out, dma_dev_out);
        end
        @(negedge clk);
        dma_end_flag   = 1'b1;
        dma_error_flag = ($urandom_range(0, 3) == 0);
        err = err | dma_error_flag;
        req_ack = '0; dma_ack_in = 1'b0;
        req_rqst = nxt;
        rand_desc();
        @(posedge clk); #1;
        check("end", req_end, oh);
        check("error", req_error, err ? oh : N'(0));
        @(negedge clk);
        dma_end_flag = 1'b0; dma_error_flag = 1'b0;
        @(posedge clk); #1;
        check("end_low", req_end, 0);
        check("err_low", req_error, 0);
        check("grant_clr", grant, 0);
        ptr = (g + 1) % N;
    endtask

    task automatic wd_xfer(input logic [N-1:0] nxt);
        int g;
        logic [N-1:0] oh;
        g = rr_pick(req_rqst, ptr);
        oh = N'(1) << g;
        @(posedge clk); #1;
        check("wd_grant", grant, oh);
        @(negedge clk);
        req_rqst = nxt; req_ack = '0; dma_ack_in = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk); #1;
            check("wd_rst", dma_rst, (c == 17 || c == 18) ? 1 : 0);
            check("wd_end", req_end, (c == 18) ? oh : N'(0));
            check("wd_err", req_error, (c == 18) ? oh : N'(0));
            check("wd_grant_hold", grant, (c <= 18) ? oh : N'(0));
        end
        ptr = (g + 1) % N;
    endtask

    initial begin
        reset = 1'b1;
        req_rqst = '0; req_ack = '0; req_data_in = '0; dma_ack_in = 1'b0;
        dma_dev_out = '0; dma_end_flag = 1'b0; dma_error_flag = 1'b0;
        for (int i = 0; i < N; i++) begin nw[i] = '0; sa[i] = '0; rw[i] = 1'b0; end
        drive_desc();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_rqst", dma_rqst, 0);
        check("rst_dma_rst", dma_rst, 0);
        check("rst_end", req_end, 0);
        check("rst_error", req_error, 0);
        check("rst_nwords", dma_num_words, 0);
        check("rst_addr", dma_start_addr, 0);
        check("rst_dev_in", dma_dev_in, 0);
        check("rst_dma_ack", req_dma_ack, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_check(3);
        @(negedge clk);
        rand_desc();
        nw[1] = 16'd4; sa[1] = 17'h0200; rw[1] = 1'b1;
        drive_desc();
        req_rqst = 4'b0010;
        run_xfer(4'b1111);
        repeat (5) run_xfer(4'b1111);
        for (int it = 0; it < 30; it++) begin
            logic [N-1:0] nxt;
            nxt = N'($urandom);
            run_xfer(nxt);
            if (nxt == 0) begin
                idle_check(2);
                @(negedge clk);
                req_rqst = N'($urandom_range(1, 15));
            end
        end
        run_xfer(4'b0010);
        wd_xfer(4'b0100);
        @(posedge clk); #1;
        check("pre_rst_grant", grant, 4'b0100);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("async_grant", grant, 0);
        check("async_rqst", dma_rqst, 0);
        check("async_end", req_end, 0);
        @(negedge clk);
        reset = 1'b0;
        req_rqst = 4'b1111;
        ptr = 0;
        run_xfer(4'b0000);
        idle_check(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
